// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Multiplexed seven-segment scan controller for N_DIGITS common-anode
//   digits. One active-low anode at a time, with per-digit blank, blink and
//   decimal point, 8-level PWM brightness and a global enable.
//
// Ports
//   CLK     : clock, rising edge
//   RST     : synchronous active-high reset
//   EN      : 1 = display on, 0 = outputs dark (counters keep running)
//   DIGITS  : packed 4-bit codes, digit i at [4i+3:4i]
//   DP      : per-digit decimal point request (1 = lit)
//   BLANK   : per-digit blank (1 = dark)
//   BLINK   : per-digit blink enable
//   BRIGHT  : on-time in eighths of a slot (7 = full)
//   AN      : active-low anodes, at most one low
//   DIGIT   : code of the lit digit, 0 when none lit
//   DP_N    : active-low decimal point of the lit digit, 1 when none lit
//   SEL     : index of the current slot (valid even when dark)
module seg_scan_driver #(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 800,
  parameter int BLINK_FRAMES = 64,
  localparam int SEL_W       = $clog2(N_DIGITS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic [4*N_DIGITS-1:0] DIGITS,
  input  logic [N_DIGITS-1:0]   DP,
  input  logic [N_DIGITS-1:0]   BLANK,
  input  logic [N_DIGITS-1:0]   BLINK,
  input  logic [2:0]            BRIGHT,
  output logic [N_DIGITS-1:0]   AN,
  output logic [3:0]            DIGIT,
  output logic                  DP_N,
  output logic [SEL_W-1:0]      SEL
);

  localparam int SUB_CNT = SCAN_DIV / 8;
  localparam int SUB_W   = (SUB_CNT > 1) ? $clog2(SUB_CNT) : 1;
  localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(SUB_CNT - 1);
  localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  // Scan counters
  logic [SUB_W-1:0] sub_q,   sub_d;
  logic [2:0]       phase_q, phase_d;
  logic [SEL_W-1:0] slot_q,  slot_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic             blink_ph_q, blink_ph_d;

  // Registered outputs
  logic [N_DIGITS-1:0] an_q,    an_d;
  logic [3:0]          digit_q, digit_d;
  logic                dpn_q,   dpn_d;
  logic [SEL_W-1:0]    sel_q,   sel_d;

  logic sub_wrap, phase_wrap, slot_wrap, frame_wrap;

  // Wrap chain: each stage only wraps when every faster stage wraps too, so
  // simultaneous terminal counts resolve on one edge.
  always_comb begin
    sub_wrap   = (sub_q == SUB_LAST);
    phase_wrap = sub_wrap && (phase_q == 3'd7);
    slot_wrap  = phase_wrap && (slot_q == SLOT_LAST);
    frame_wrap = slot_wrap && (frame_q == FRM_LAST);
  end

  always_comb begin
    sub_d      = sub_wrap ? '0 : sub_q + 1'b1;
    phase_d    = sub_wrap ? phase_q + 3'd1 : phase_q;
    slot_d     = slot_q;
    frame_d    = frame_q;
    blink_ph_d = blink_ph_q;
    if (phase_wrap) begin
      slot_d = slot_wrap ? '0 : slot_q + 1'b1;
    end
    if (slot_wrap) begin
      frame_d = frame_wrap ? '0 : frame_q + 1'b1;
    end
    if (frame_wrap) begin
      blink_ph_d = ~blink_ph_q;
    end
  end

  // Output decode from the current counter state and live inputs.
  // Digit selection is a one-hot compare loop so a non-power-of-2 N_DIGITS
  // never indexes past the input vectors.
  logic       blank_s, blink_s, dp_s, lit;
  logic [3:0] code_s;

  always_comb begin
    blank_s = 1'b0;
    blink_s = 1'b0;
    dp_s    = 1'b0;
    code_s  = 4'h0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (slot_q == SEL_W'(i)) begin
        blank_s = BLANK[i];
        blink_s = BLINK[i];
        dp_s    = DP[i];
        code_s  = DIGITS[4*i +: 4];
      end
    end

    lit = EN && !blank_s && !(blink_s && blink_ph_q) && (phase_q <= BRIGHT);

    an_d = '1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (lit && (slot_q == SEL_W'(i))) begin
        an_d[i] = 1'b0;
      end
    end
    digit_d = lit ? code_s : 4'h0;
    dpn_d   = !(lit && dp_s);
    sel_d   = slot_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sub_q      <= '0;
      phase_q    <= '0;
      slot_q     <= '0;
      frame_q    <= '0;
      blink_ph_q <= 1'b0;
      an_q       <= '1;
      digit_q    <= 4'h0;
      dpn_q      <= 1'b1;
      sel_q      <= '0;
    end else begin
      sub_q      <= sub_d;
      phase_q    <= phase_d;
      slot_q     <= slot_d;
      frame_q    <= frame_d;
      blink_ph_q <= blink_ph_d;
      an_q       <= an_d;
      digit_q    <= digit_d;
      dpn_q      <= dpn_d;
      sel_q      <= sel_d;
    end
  end

  assign AN    = an_q;
  assign DIGIT = digit_q;
  assign DP_N  = dpn_q;
  assign SEL   = sel_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int SD = 16;
  localparam int BF = 2;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp, blank, blink;
  logic [2:0]  bright;

  logic [3:0]  an4;
  logic [3:0]  dig4;
  logic        dpn4;
  logic [1:0]  sel4;
  logic [2:0]  an3;
  logic [3:0]  dig3;
  logic        dpn3;
  logic [1:0]  sel3;

  int n_chk  = 0;
  int n_fail = 0;

  seg_scan_driver #(.N_DIGITS(4), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut4 (
    .CLK(clk), .RST(rst), .EN(en), .DIGITS(digits), .DP(dp), .BLANK(blank),
    .BLINK(blink), .BRIGHT(bright), .AN(an4), .DIGIT(dig4), .DP_N(dpn4), .SEL(sel4)
  );

  seg_scan_driver #(.N_DIGITS(3), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut3 (
    .CLK(clk), .RST(rst), .EN(en), .DIGITS(digits[11:0]), .DP(dp[2:0]),
    .BLANK(blank[2:0]), .BLINK(blink[2:0]), .BRIGHT(bright),
    .AN(an3), .DIGIT(dig3), .DP_N(dpn3), .SEL(sel3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Display state after c scan cycles since reset, from the timing rules:
  // slot = c/SCAN_DIV mod n, phase = eighth of the slot, blink phase =
  // parity of the number of completed blink half-periods.
  function automatic void model(input int n, input int unsigned c, input logic e,
                                input logic [15:0] dg, input logic [3:0] p,
                                input logic [3:0] bk, input logic [3:0] bl,
                                input logic [2:0] br, output logic [3:0] a,
                                output logic [3:0] d, output logic pn,
                                output logic [1:0] s);
    int unsigned slot, phase, bph;
    logic lit;
    slot  = (c / SD) % n;
    phase = (c % SD) / (SD / 8);
    bph   = (c / (BF * n * SD)) % 2;
    lit   = e && !bk[slot] && !(bl[slot] && bph == 1) && (phase <= br);
    a = 4'hF;
    if (lit) a[slot] = 1'b0;
    d  = lit ? dg[4*slot +: 4] : 4'h0;
    pn = !(lit && p[slot]);
    s  = 2'(slot);
  endfunction

  logic        started = 1'b0;
  int unsigned cyc = 0;
  logic [3:0]  e4a, e4d, e3a, e3d;
  logic        e4p, e3p;
  logic [1:0]  e4s, e3s;

  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      cyc = 0;
      e4a = 4'hF; e4d = 4'h0; e4p = 1'b1; e4s = 2'd0;
      e3a = 4'hF; e3d = 4'h0; e3p = 1'b1; e3s = 2'd0;
    end else begin
      model(4, cyc, en, digits, dp, blank, blink, bright, e4a, e4d, e4p, e4s);
      model(3, cyc, en, digits, dp, blank, blink, bright, e3a, e3d, e3p, e3s);
      cyc++;
    end
    #1;
    if (started) begin
      chk("AN4", an4, e4a);
      chk("DIGIT4", dig4, e4d);
      chk("DP_N4", dpn4, e4p);
      chk("SEL4", sel4, e4s);
      chk("AN3", an3, e3a[2:0]);
      chk("DIGIT3", dig3, e3d);
      chk("DP_N3", dpn3, e3p);
      chk("SEL3", sel3, e3s);
    end
  end

  task automatic edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; digits = 16'h4321;
    dp = 4'b0000; blank = 4'b0000; blink = 4'b0000; bright = 3'd7;

    edges(2);
    chk("rst_AN", an4, 4'hF);
    chk("rst_DIGIT", dig4, 4'h0);
    chk("rst_DPN", dpn4, 1'b1);
    chk("rst_SEL", sel4, 2'd0);

    // Full brightness scan
    @(negedge clk); rst = 1'b0;
    edges(1);  chk("A_e1_AN", an4, 4'b1110); chk("A_e1_DIG", dig4, 4'h1); chk("A_e1_SEL3", sel3, 2'd0);
    edges(16); chk("A_e17_AN", an4, 4'b1101); chk("A_e17_DIG", dig4, 4'h2); chk("A_e17_SEL3", sel3, 2'd1);
    edges(16); chk("A_e33_AN", an4, 4'b1011); chk("A_e33_DIG", dig4, 4'h3); chk("A_e33_SEL3", sel3, 2'd2);
    edges(16); chk("A_e49_AN", an4, 4'b0111); chk("A_e49_SEL", sel4, 2'd3);
               chk("A_e49_SEL3", sel3, 2'd0); chk("A_e49_AN3", an3, 3'b110);
    edges(16); chk("A_e65_AN", an4, 4'b1110); chk("A_e65_DIG", dig4, 4'h1);

    // Brightness 1: four lit cycles then dark
    bright = 3'd1;
    do_reset();
    edges(4); chk("B_e4_AN", an4, 4'b1110);
    edges(1); chk("B_e5_AN", an4, 4'b1111); chk("B_e5_DIG", dig4, 4'h0); chk("B_e5_DPN", dpn4, 1'b1);
    edges(60);

    // Blank and decimal point
    bright = 3'd7; blank = 4'b0100; dp = 4'b0001;
    do_reset();
    edges(1);  chk("C_e1_DPN", dpn4, 1'b0); chk("C_e1_AN", an4, 4'b1110);
    edges(32); chk("C_e33_AN", an4, 4'b1111); chk("C_e33_DIG", dig4, 4'h0); chk("C_e33_SEL", sel4, 2'd2);
    edges(16); chk("C_e49_AN", an4, 4'b0111); chk("C_e49_DPN", dpn4, 1'b1);
    edges(20);

    // Blink, enable drop, and reset mid-frame during dark blink phase
    blank = 4'b0000; dp = 4'b0000; blink = 4'b0010;
    do_reset();
    edges(17);  chk("D_e17_AN", an4, 4'b1101);
    edges(128); chk("D_e145_AN", an4, 4'b1111); chk("D_e145_SEL", sel4, 2'd1);
    edges(5);
    @(negedge clk); en = 1'b0;
    edges(1);  chk("E_off_AN", an4, 4'b1111); chk("E_off_SEL", sel4, 2'd1);
    edges(20); chk("E_off2_AN", an4, 4'b1111); chk("E_off2_SEL", sel4, 2'd2);
    @(negedge clk); en = 1'b1;
    edges(1);  chk("E_on_AN", an4, 4'b1011);
    edges(8);
    @(negedge clk); rst = 1'b1;
    edges(1);  chk("E_rst_AN", an4, 4'hF); chk("E_rst_DIG", dig4, 4'h0);
               chk("E_rst_DPN", dpn4, 1'b1); chk("E_rst_SEL", sel4, 2'd0);
    @(negedge clk); rst = 1'b0;
    edges(1);   chk("E_r1_AN", an4, 4'b1110); chk("E_r1_SEL", sel4, 2'd0);
    edges(16);  chk("E_r17_AN", an4, 4'b1101);
    edges(256); chk("D_e273_AN", an4, 4'b1101); chk("D_e273_DIG", dig4, 4'h2);

    // Mid-slot input changes
    @(negedge clk); bright = 3'd3; digits = 16'h9A5C; dp = 4'b1010;
    edges(40);
    @(negedge clk); bright = 3'd0; blank = 4'b1000;
    edges(40);
    @(negedge clk); bright = 3'd7; blink = 4'b0000; blank = 4'b0000;
    edges(70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
